// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite master behind a cmd/rsp port.
// Optional watchdog compiled in with `define AXI_LITE_MASTER_TIMEOUT_EN.
module axi_lite_master #(
   parameter int ADDR_WIDTH     = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_write,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic [ADDR_WIDTH-1:0]   AWADDR,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   output logic [DATA_WIDTH-1:0]   WDATA,
   output logic [DATA_WIDTH/8-1:0] WSTRB,
   output logic                    WVALID,
   input  logic                    WREADY,
   input  logic                    BVALID,
   output logic                    BREADY,
   output logic [ADDR_WIDTH-1:0]   ARADDR,
   output logic                    ARVALID,
   input  logic                    ARREADY,
   input  logic [DATA_WIDTH-1:0]   RDATA,
   input  logic                    RVALID,
   output logic                    RREADY
);

   localparam int SW = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP
   } state_e;

   state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [SW-1:0]         wstrb_q, wstrb_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic awvalid_q, awvalid_d;
   logic wvalid_q, wvalid_d;
   logic bready_q, bready_d;
   logic arvalid_q, arvalid_d;
   logic rready_q, rready_d;
   logic rsp_valid_q, rsp_valid_d;
   logic rsp_write_q, rsp_write_d;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic aw_done, w_done;
   logic to_hit;

   assign aw_hs   = awvalid_q && AWREADY;
   assign w_hs    = wvalid_q && WREADY;
   assign b_hs    = BVALID && bready_q;
   assign ar_hs   = arvalid_q && ARREADY;
   assign r_hs    = RVALID && rready_q;
   // A channel whose VALID is already low finished on an earlier edge.
   assign aw_done = !awvalid_q || AWREADY;
   assign w_done  = !wvalid_q || WREADY;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          rsp_err_q, rsp_err_d;
   logic          busy, any_hs;

   assign busy   = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                   (state_q == RD_REQ) || (state_q == RD_DATA);
   assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;
   // Fires on the edge where the count would reach the limit.
   assign to_hit = busy && !any_hs &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   // Watchdog count and sticky error flag for the pending response.
   always_comb begin
      cnt_d     = cnt_q;
      rsp_err_d = rsp_err_q;
      if (!busy || any_hs) cnt_d = '0;
      else                 cnt_d = cnt_q + 1'b1;
      if (to_hit)
         rsp_err_d = 1'b1;
      else if (state_q == RSP && rsp_ready)
         rsp_err_d = 1'b0;
   end

   // Watchdog registers.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         cnt_q     <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   assign to_hit  = 1'b0;
   assign rsp_err = 1'b0;
`endif

   // State register.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cmd_valid) state_d = cmd_write ? WR_REQ : RD_REQ;
         WR_REQ:  if (aw_done && w_done) state_d = WR_RESP;
         WR_RESP: if (b_hs) state_d = RSP;
         RD_REQ:  if (ar_hs) state_d = RD_DATA;
         RD_DATA: if (r_hs) state_d = RSP;
         RSP:     if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (to_hit) state_d = RSP;
   end

   // Next values of the registered AXI and response outputs.
   always_comb begin
      awaddr_d    = awaddr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      araddr_d    = araddr_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_write) begin
               awaddr_d  = cmd_addr;
               wdata_d   = cmd_wdata;
               wstrb_d   = cmd_wstrb;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
            end else if (cmd_valid) begin
               araddr_d  = cmd_addr;
               arvalid_d = 1'b1;
            end
         end
         WR_REQ: begin
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            if (aw_done && w_done) bready_d = 1'b1;
         end
         WR_RESP: begin
            if (b_hs) begin
               bready_d    = 1'b0;
               rsp_write_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_valid_d = 1'b1;
            end
         end
         RD_REQ: begin
            if (ar_hs) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         RD_DATA: begin
            if (r_hs) begin
               rready_d    = 1'b0;
               rsp_write_d = 1'b0;
               rsp_rdata_d = RDATA;
               rsp_valid_d = 1'b1;
            end
         end
         RSP: begin
            if (rsp_ready) rsp_valid_d = 1'b0;
         end
         default: ;
      endcase
      if (to_hit) begin
         awvalid_d   = 1'b0;
         wvalid_d    = 1'b0;
         bready_d    = 1'b0;
         arvalid_d   = 1'b0;
         rready_d    = 1'b0;
         rsp_write_d = (state_q == WR_REQ) || (state_q == WR_RESP);
         rsp_rdata_d = '0;
         rsp_valid_d = 1'b1;
      end
   end

   // Output registers; reset abandons any transaction in flight.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         awaddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         araddr_q    <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         araddr_q    <= araddr_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign AWADDR    = awaddr_q;
   assign AWVALID   = awvalid_q;
   assign WDATA     = wdata_q;
   assign WSTRB     = wstrb_q;
   assign WVALID    = wvalid_q;
   assign BREADY    = bready_q;
   assign ARADDR    = araddr_q;
   assign ARVALID   = arvalid_q;
   assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed vectors against a behavioural register slave.
// Timeout sequence only runs when AXI_LITE_MASTER_TIMEOUT_EN is defined.
module tb_axi_lite_master;

   logic        ACLK, ARESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [3:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
   logic [31:0] rsp_rdata;
   logic [3:0]  AWADDR, ARADDR;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic [31:0] WDATA, RDATA;
   logic [3:0]  WSTRB;
   logic        ARVALID, ARREADY, RVALID, RREADY;

   axi_lite_master #(
      .ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   // ---------------- behavioural slave ----------------
   logic        sl_fast, sl_stall, sl_bhold;
   logic        awr_r, wr_r, arr_r, bvalid_r, rvalid_r;
   logic [31:0] rdata_r;
   logic        got_aw, got_w;
   logic [3:0]  s_addr, s_strb;
   logic [31:0] s_data;
   logic [31:0] mem [4];
   logic        aw_now, w_now;
   logic [3:0]  a_now, st_now;
   logic [31:0] d_now;

   assign AWREADY = !sl_stall && (sl_fast || awr_r);
   assign WREADY  = !sl_stall && (sl_fast || wr_r);
   assign ARREADY = sl_fast || arr_r;
   assign BVALID  = bvalid_r;
   assign RVALID  = rvalid_r;
   assign RDATA   = rdata_r;
   assign aw_now  = got_aw || (AWVALID && AWREADY);
   assign w_now   = got_w || (WVALID && WREADY);
   assign a_now   = got_aw ? s_addr : AWADDR;
   assign d_now   = got_w ? s_data : WDATA;
   assign st_now  = got_w ? s_strb : WSTRB;

   always @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         awr_r <= 0; wr_r <= 0; arr_r <= 0;
         bvalid_r <= 0; rvalid_r <= 0; rdata_r <= 0;
         got_aw <= 0; got_w <= 0;
         s_addr <= 0; s_data <= 0; s_strb <= 0;
         for (int i = 0; i < 4; i++) mem[i] <= 0;
      end else begin
         awr_r <= AWVALID && !awr_r;
         wr_r  <= WVALID && !wr_r;
         arr_r <= ARVALID && !arr_r;
         if (aw_now && w_now && !bvalid_r && !sl_bhold) begin
            for (int i = 0; i < 4; i++)
               if (st_now[i]) mem[a_now[3:2]][8*i +: 8] <= d_now[8*i +: 8];
            bvalid_r <= 1;
            got_aw   <= 0;
            got_w    <= 0;
         end else begin
            if (AWVALID && AWREADY) begin
               got_aw <= 1; s_addr <= AWADDR;
            end
            if (WVALID && WREADY) begin
               got_w <= 1; s_data <= WDATA; s_strb <= WSTRB;
            end
            if (BVALID && BREADY) bvalid_r <= 0;
         end
         if (ARVALID && ARREADY) begin
            rvalid_r <= 1;
            rdata_r  <= mem[ARADDR[3:2]];
         end else if (RVALID && RREADY) begin
            rvalid_r <= 0;
         end
      end
   end

   // ---------------- protocol monitor ----------------
   int          viol, arv_cycles, ar_hs_cnt;
   logic        p_aw, p_awr, p_w, p_wr, p_ar, p_arr;
   logic [3:0]  p_awaddr, p_araddr, p_wstrb;
   logic [31:0] p_wdata;

   always @(negedge ACLK) begin
      if (!ARESETn) begin
         p_aw = 0; p_w = 0; p_ar = 0;
         p_awr = 0; p_wr = 0; p_arr = 0;
      end else begin
         if (!sl_stall) begin
            if (p_aw && !p_awr && (!AWVALID || AWADDR != p_awaddr))
               viol++;
            if (p_w && !p_wr &&
                (!WVALID || WDATA != p_wdata || WSTRB != p_wstrb))
               viol++;
         end
         if (p_ar && !p_arr && (!ARVALID || ARADDR != p_araddr))
            viol++;
         if ((AWVALID || WVALID || BREADY) && (ARVALID || RREADY))
            viol++;
         if (ARVALID) arv_cycles++;
         if (ARVALID && ARREADY) ar_hs_cnt++;
         p_aw = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
         p_w = WVALID; p_wr = WREADY; p_wdata = WDATA; p_wstrb = WSTRB;
         p_ar = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
      end
   end

   // ---------------- checking helpers ----------------
   int pass_cnt, total_cnt;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      else
         pass_cnt++;
   endtask

   task automatic do_cmd(input logic w, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output logic rw, output logic [31:0] rd,
                         output logic re, output int lat);
      int n;
      cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      cmd_valid = 1;
      n = 0;
      do begin
         @(negedge ACLK); n++;
      end while (!cmd_ready && n < 20);
      if (!cmd_ready) begin
         total_cnt++;
         $display("FAIL cmd_accept: cmd_ready=0 after %0d cycles", n);
      end
      @(posedge ACLK); #1 cmd_valid = 0;
      lat = 0;
      do begin
         @(negedge ACLK); lat++;
      end while (!rsp_valid && lat < 100);
      if (!rsp_valid) begin
         total_cnt++;
         $display("FAIL rsp_wait: rsp_valid=0 after %0d cycles", lat);
      end
      rw = rsp_write; rd = rsp_rdata; re = rsp_err;
      if (rsp_ready) begin
         @(posedge ACLK); #1;
      end
   endtask

   typedef struct {
      logic        w;
      logic [3:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        fast;
      logic [31:0] exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t        tbl[10];
   logic        rw, re;
   logic [31:0] rd;
   int          lat, bad, n, c0;

   initial begin
      tbl[0] = '{1, 4'h4, 32'hDEADBEEF, 4'hF, 0, 32'h0,        4};
      tbl[1] = '{0, 4'h4, 32'h0,        4'h0, 0, 32'hDEADBEEF, 4};
      tbl[2] = '{1, 4'h4, 32'h000000AA, 4'h1, 1, 32'h0,        3};
      tbl[3] = '{0, 4'h4, 32'h0,        4'h0, 1, 32'hDEADBEAA, 3};
      tbl[4] = '{1, 4'h8, 32'h12345678, 4'hC, 1, 32'h0,        3};
      tbl[5] = '{0, 4'h8, 32'h0,        4'h0, 0, 32'h12340000, 4};
      tbl[6] = '{1, 4'h0, 32'hA5A5A5A5, 4'hF, 0, 32'h0,        4};
      tbl[7] = '{0, 4'h0, 32'h0,        4'h0, 1, 32'hA5A5A5A5, 3};
      tbl[8] = '{1, 4'h8, 32'h0000FF00, 4'h2, 0, 32'h0,        4};
      tbl[9] = '{0, 4'h8, 32'h0,        4'h0, 1, 32'h1234FF00, 3};

      pass_cnt = 0; total_cnt = 0; viol = 0;
      arv_cycles = 0; ar_hs_cnt = 0;
      sl_fast = 0; sl_stall = 0; sl_bhold = 0;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0;
      cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 1;
      ARESETn = 0;
      #1;
      chk("reset_ctrl", 32'({AWVALID, WVALID, BREADY, ARVALID,
                             RREADY, rsp_valid, rsp_err}), 32'h0);
      chk("reset_data", AWADDR | ARADDR | WDATA | 32'(WSTRB), 32'h0);
      chk("reset_cmd_ready", 32'(cmd_ready), 32'h1);
      repeat (2) @(posedge ACLK);
      @(negedge ACLK); ARESETn = 1;
      @(posedge ACLK); #1;

      // Read of an untouched register with ARREADY one cycle late.
      arv_cycles = 0;
      do_cmd(0, 4'hC, 32'h0, 4'h0, rw, rd, re, lat);
      chk("rd_c_data", rd, 32'h0);
      chk("rd_c_write", 32'(rw), 32'h0);
      chk("rd_c_arvalid_cycles", 32'(arv_cycles), 32'd2);
      chk("rd_c_latency", 32'(lat), 32'd4);

      for (int i = 0; i < 10; i++) begin
         sl_fast = tbl[i].fast;
         do_cmd(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, rw, rd, re, lat);
         chk($sformatf("vec%0d_write", i), 32'(rw), 32'(tbl[i].w));
         chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
         chk($sformatf("vec%0d_err", i), 32'(re), 32'h0);
         chk($sformatf("vec%0d_latency", i), 32'(lat),
             32'(tbl[i].exp_lat));
      end
      sl_fast = 0;

      // Response back-pressure with a competing command held high.
      c0 = ar_hs_cnt;
      rsp_ready = 0;
      do_cmd(0, 4'h4, 32'h0, 4'h0, rw, rd, re, lat);
      chk("bp_first_rdata", rd, 32'hDEADBEAA);
      cmd_write = 0; cmd_addr = 4'h8; cmd_valid = 1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK);
         if (!rsp_valid || rsp_rdata != 32'hDEADBEAA || !rsp_write == 0 ||
             cmd_ready || ARVALID)
            bad++;
      end
      chk("bp_hold_errors", 32'(bad), 32'h0);
      cmd_valid = 0;
      rsp_ready = 1;
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("bp_release", 32'({cmd_ready, rsp_valid, ARVALID}), 32'h4);
      chk("bp_ar_count", 32'(ar_hs_cnt - c0), 32'd1);

      // Reset while waiting for the write response.
      sl_bhold = 1;
      cmd_write = 1; cmd_addr = 4'h8; cmd_wdata = 32'h55AA55AA;
      cmd_wstrb = 4'hF; cmd_valid = 1;
      @(negedge ACLK);
      @(posedge ACLK); #1 cmd_valid = 0;
      n = 0;
      do begin
         @(negedge ACLK); n++;
      end while (!BREADY && n < 20);
      chk("wr_resp_reached", 32'(BREADY), 32'h1);
      #2 ARESETn = 0;
      #1;
      chk("midrst_ctrl", 32'({AWVALID, WVALID, BREADY, ARVALID,
                              RREADY, rsp_valid}), 32'h0);
      chk("midrst_data", AWADDR | WDATA | 32'(WSTRB), 32'h0);
      @(posedge ACLK);
      @(negedge ACLK); #1 ARESETn = 1; sl_bhold = 0;
      @(negedge ACLK);
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'h1);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         if (rsp_valid) bad++;
      end
      chk("midrst_no_rsp", 32'(bad), 32'h0);
      @(posedge ACLK); #1;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
      // Slave never accepts AW/W: watchdog must complete the command.
      sl_stall = 1;
      do_cmd(1, 4'h4, 32'h11111111, 4'hF, rw, rd, re, lat);
      chk("to_latency", 32'(lat), 32'd9);
      chk("to_err", 32'(re), 32'h1);
      chk("to_write", 32'(rw), 32'h1);
      chk("to_rdata", rd, 32'h0);
      chk("to_valids", 32'({AWVALID, WVALID}), 32'h0);
      @(negedge ACLK);
      chk("to_err_clear", 32'({rsp_err, cmd_ready}), 32'h1);
      sl_stall = 0;
`endif

      chk("protocol_violations", 32'(viol), 32'h0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
